// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execution unit
//
// Purpose: executes MUL/MULH/MULHSU/MULHU in one cycle and DIV/DIVU/REM/REMU
// with a 32-iteration restoring divider, using a start/busy/done handshake.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start_i   launch an operation (sampled only in IDLE)
//   op_i      funct3 operation select
//   rs1_i     operand A (multiplicand / dividend)
//   rs2_i     operand B (multiplier / divisor)
//   flush_i   abort the current operation, no completion pulse
//   busy_o    high while the divider iterates or fixes up signs
//   done_o    one-cycle completion pulse, result_o valid with it
//   result_o  registered result, held until the next completion
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] q_q, q_d;          // dividend shifting out, quotient shifting in
  logic [XLEN:0]   rem_q, rem_d;      // partial remainder
  logic [XLEN-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [4:0]      cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            rem_sel_q, rem_sel_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Multiply: each operand becomes a 33-bit value whose top bit is the sign
  // (signed ops) or 0 (unsigned ops), then is sign-extended to 64 bits so a
  // plain 64-bit product equals the signed 33x33 product modulo 2^64.
  logic        a_sx, b_sx;
  logic [32:0] a_ext, b_ext;
  logic [63:0] a64, b64, prod;
  logic [31:0] mul_res;

  assign a_sx  = (op_i[1:0] != 2'b11);   // MUL, MULH, MULHSU sign-extend rs1
  assign b_sx  = ~op_i[1];               // MUL, MULH sign-extend rs2
  assign a_ext = {a_sx & rs1_i[31], rs1_i};
  assign b_ext = {b_sx & rs2_i[31], rs2_i};
  assign a64   = {{31{a_ext[32]}}, a_ext};
  assign b64   = {{31{b_ext[32]}}, b_ext};
  assign prod  = a64 * b64;
  assign mul_res = (op_i[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

  // Divide setup: op_i[0]=1 selects unsigned, op_i[1]=1 selects remainder.
  logic        div_signed, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag;

  assign div_signed = ~op_i[0];
  assign div_zero   = (rs2_i == '0);
  assign div_ovf    = div_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
  assign a_mag      = (div_signed && rs1_i[31]) ? (~rs1_i + 32'd1) : rs1_i;
  assign b_mag      = (div_signed && rs2_i[31]) ? (~rs2_i + 32'd1) : rs2_i;

  // Trial subtraction on the shifted remainder; bit 33 set means it went
  // negative, i.e. the shifted remainder was smaller than the divisor.
  logic [33:0] trial;
  logic        ge;

  assign trial = {rem_q, q_q[31]} - {2'b00, dvs_q};
  assign ge    = ~trial[33];

  logic [31:0] quot_fix, rem_fix;

  assign quot_fix = qneg_q ? (~q_q + 32'd1) : q_q;
  assign rem_fix  = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (!op_i[2]) begin
            result_d = mul_res;
            state_d  = S_DONE;
          end else if (div_zero) begin
            result_d = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = op_i[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            q_d       = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            cnt_d     = '0;
            qneg_d    = div_signed && (rs1_i[31] ^ rs2_i[31]);
            rneg_d    = div_signed && rs1_i[31];
            rem_sel_d = op_i[1];
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = ge ? trial[32:0] : {rem_q[31:0], q_q[31]};
        q_d   = {q_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = rem_sel_q ? rem_fix : quot_fix;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Squash beats everything, including a start in the same cycle.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      rem_sel_q <= rem_sel_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking scoreboard bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          t;
  } exp_t;

  exp_t sb[$];
  logic [31:0] last_res;

  // Completion monitor: every done_o pulse must match the oldest expectation
  // in value and in the cycle it shows up.
  always @(negedge clk) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq(e.tag, result_o, e.res);
        check_eq({e.tag, "_cycle"}, 32'(edges), 32'(e.t));
      end
    end
  end

  // Issue one operation at a negedge and follow it to completion. lat is 1
  // for single-cycle results and 34 for iterating divides. poke asserts a
  // stray start with different operands while the divider is busy.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit poke);
    exp_t e;
    int   t;
    bit   seen;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    t       = edges + 1;
    e.tag   = tag;
    e.res   = exp;
    e.t     = t + lat - 1;
    sb.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    seen    = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      check_eq({tag, "_busy"}, {31'd0, busy_o}, {31'd0, (lat == 34) && (k <= 32)});
      if (done_o) begin
        seen = 1'b1;
      end else begin
        start_i = poke && (k == 5);
        if (poke && k == 5) begin
          op_i  = OP_MUL;
          rs1_i = 32'd3;
          rs2_i = 32'd3;
        end
        @(negedge clk);
        start_i = 1'b0;
      end
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_drop"}, {31'd0, done_o}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_result", result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);
    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 0);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run_op("mul_big", OP_MUL,   32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1, 0);
    run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu",   OP_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34, 0);
    run_op("remu",   OP_REMU,   32'd100,       32'd7,         32'd2,         34, 0);
    run_op("div_neg_div", OP_DIV, 32'd100,     32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
    run_op("div0",   OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("remu0",  OP_REMU,   32'd5,         32'd0,         32'd5,         1, 0);
    run_op("ovf_div", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("ovf_rem", OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

    // Flush during cycle T+10 of a divide, then restart in T+11.
    start_i = 1'b1; op_i = OP_DIV; rs1_i = 32'hFFFF_FFF9; rs2_i = 32'd2;
    t = edges + 1;
    @(negedge clk);
    start_i = 1'b0;
    while (edges < t + 9) @(negedge clk);
    check_eq("flush_busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("flush_busy_after", {31'd0, busy_o}, 32'd0);
    check_eq("flush_result_kept", result_o, last_res);
    run_op("div_after_flush", OP_DIV, 32'd100, 32'd7, 32'd14, 34, 0);

    // Reset during cycle T+20 of a divide.
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
    t = edges + 1;
    @(negedge clk);
    start_i = 1'b0;
    while (edges < t + 19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("midrst_done", {31'd0, done_o}, 32'd0);
    check_eq("midrst_result", result_o, 32'd0);
    repeat (40) @(negedge clk);
    check_eq("midrst_busy_late", {31'd0, busy_o}, 32'd0);

    // start together with flush in IDLE starts nothing.
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd9; rs2_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check_eq("startflush_done", {31'd0, done_o}, 32'd0);
    check_eq("startflush_result", result_o, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("startflush_busy", {31'd0, busy_o}, 32'd0);

    // Stray start while busy is ignored.
    run_op("div_poked", OP_DIV, 32'd1000, 32'd3, 32'd333, 34, 1);
    repeat (3) @(negedge clk);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
